bitrate_stats_collector: RTL and testbench
==========================================

BITRATE_STATS_COLLECTOR -- requirements
Module: bitrate_stats_collector

Interface
REQ-001 Parameter COUNTER_WIDTH, default 32, width of each bitrate sample.
REQ-002 Parameter FIFO_DEPTH, default 16, sample FIFO entries; power of two, >= 2.
REQ-003 Parameter AVG_LOG2, default 3, averaging window of 2^AVG_LOG2 samples.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sample_valid  in  1  one-cycle strobe; sample_bitrate is valid this cycle.
REQ-007 sample_bitrate  in  COUNTER_WIDTH  per-window bitrate from the upstream sniffer.
REQ-008 clear  in  1  synchronous soft clear of stats, FIFO and flags.
REQ-009 rd_en  in  1  pop request for the FIFO head.
REQ-010 rd_data  out  COUNTER_WIDTH  FIFO head; first-word fall-through.
REQ-011 fifo_empty / fifo_full  out  1 each  FIFO status.
REQ-012 fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.
REQ-013 last_bitrate / min_bitrate / max_bitrate / avg_bitrate  out  COUNTER_WIDTH each  statistics.
REQ-014 stats_valid  out  1  high once at least one sample is accepted since reset/clear.
REQ-015 avg_valid  out  1  one-cycle pulse when avg_bitrate updates.
REQ-016 overflow  out  1  sticky; a sample was dropped because the FIFO was full.
REQ-017 drop_count  out  16  dropped-sample count, saturates at 0xFFFF.

Function
REQ-018 Samples are always accepted; no backpressure to upstream.
REQ-019 FSM states NO_DATA and ACTIVE: NO_DATA -> ACTIVE on first accepted sample; any state -> NO_DATA on reset or clear; stats_valid = (state == ACTIVE).
REQ-020 last_bitrate updates the cycle after sample_valid (1-cycle latency).
REQ-021 In NO_DATA the first sample loads both min_bitrate and max_bitrate; in ACTIVE, unsigned compare-and-replace; equal values leave registers unchanged.
REQ-022 Accumulator width COUNTER_WIDTH+AVG_LOG2, no overflow possible; sample counter width AVG_LOG2.
REQ-023 On the 2^AVG_LOG2-th sample: avg_bitrate <= (sum + sample) >> AVG_LOG2 (truncating); avg_valid pulses the following cycle; accumulator and counter restart at zero.
REQ-024 Each accepted sample is pushed into the FIFO; rd_data shows the head whenever fifo_empty = 0.
REQ-025 rd_en with fifo_empty = 1 is ignored; no state change, no flag.
REQ-026 Push when full and no pop: sample is dropped from the FIFO only (stats still update), overflow set, drop_count increments.
REQ-027 Push and pop in the same cycle while full: both execute, count unchanged, no drop.
REQ-028 Push and pop in the same cycle while empty: push only, count becomes 1.
REQ-029 FIFO pointers wrap modulo FIFO_DEPTH; fifo_full = (fifo_count == FIFO_DEPTH).
REQ-030 clear has priority over a simultaneous sample_valid or rd_en; the sample is discarded.

Reset
REQ-031 On reset = 1 at a clk rising edge, all outputs return to 0 except fifo_empty = 1; state = NO_DATA; pointers, accumulator and counters are 0.
REQ-032 clear produces the same result as reset.
REQ-033 Reset asserted mid-operation discards all FIFO contents and partial averages; no stale avg_valid pulse after release.

Structure
REQ-034 Package bitrate_stats_pkg holds the default parameter constants and the FSM state enum (NO_DATA, ACTIVE).
REQ-035 The FIFO is a sub-module sample_fifo (FWFT, clk/reset/clear, push/pop, count/full/empty); stats logic lives in the top module.

Verification (FIFO_DEPTH=16, AVG_LOG2=3)
REQ-036 Reset held 10 cycles -> all outputs 0, fifo_empty = 1, stats_valid = 0.
REQ-037 Samples 100, 300, 200 -> min 100, max 300, last 200, fifo_count 3, rd_data 100; three pops return 100, 300, 200, then fifo_empty = 1.
REQ-038 Eight samples of 51200 -> avg_bitrate 51200, avg_valid high exactly one cycle, one cycle after the 8th sample; samples 1..8 -> avg 4 (36>>3).
REQ-039 17 samples with no reads -> fifo_full = 1, overflow = 1, drop_count 1; 16 pops return samples 1..16 in order.
REQ-040 FIFO full, then push and rd_en in the same cycle -> fifo_count stays 16, drop_count unchanged, new sample is last out.
REQ-041 clear asserted with sample_valid after 5 samples -> next cycle all stats 0, fifo_empty = 1, stats_valid = 0, sample not stored.

Source files
------------

// File: rtl/bitrate_stats_pkg.sv
// bitrate_stats_pkg: default parameters and FSM state type shared by the bitrate statistics collector.
package bitrate_stats_pkg;
    localparam int DEF_COUNTER_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH    = 16;
    localparam int DEF_AVG_LOG2      = 3;
    typedef enum logic {NO_DATA, ACTIVE} state_e;
endpackage

// File: rtl/bitrate_stats_collector_fifo.sv
// sample_fifo: first-word fall-through sample FIFO.
//   clk, reset (sync, active-high), clear (sync soft clear)
//   push/din write a sample; pop removes the head shown on dout
//   count/full/empty report occupancy; dout is 0 while empty
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // A pop frees a slot in the same cycle, so a push while full still lands if paired with a pop.
    always_comb begin
        do_pop   = pop && count_q != '0;
        do_push  = push && (count_q != (AW+1)'(DEPTH) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= din;
    end

    assign empty = count_q == '0;
    assign full  = count_q == (AW+1)'(DEPTH);
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/bitrate_stats_collector.sv
// bitrate_stats_collector: buffers bitrate samples and tracks last/min/max/windowed-average statistics.
//   clk, reset (sync, active-high), clear (sync soft clear of everything)
//   sample_valid/sample_bitrate: incoming samples, never back-pressured
//   rd_en/rd_data/fifo_*: FWFT sample FIFO read side and status
//   last/min/max/avg_bitrate, stats_valid, avg_valid: statistics
//   overflow (sticky) and drop_count (saturating) report FIFO drops
module bitrate_stats_collector
    import bitrate_stats_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int AVG_LOG2      = DEF_AVG_LOG2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_valid,
    input  logic [COUNTER_WIDTH-1:0]      sample_bitrate,
    input  logic                          clear,
    input  logic                          rd_en,
    output logic [COUNTER_WIDTH-1:0]      rd_data,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [COUNTER_WIDTH-1:0]      last_bitrate,
    output logic [COUNTER_WIDTH-1:0]      min_bitrate,
    output logic [COUNTER_WIDTH-1:0]      max_bitrate,
    output logic [COUNTER_WIDTH-1:0]      avg_bitrate,
    output logic                          stats_valid,
    output logic                          avg_valid,
    output logic                          overflow,
    output logic [15:0]                   drop_count
);
    localparam int ACC_W = COUNTER_WIDTH + AVG_LOG2;

    state_e                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] last_q, last_d, min_q, min_d, max_q, max_d, avg_q, avg_d;
    logic [ACC_W-1:0]         acc_q, acc_d, sum;
    logic [AVG_LOG2-1:0]      cnt_q, cnt_d;
    logic                     avg_valid_q, avg_valid_d, overflow_q, overflow_d;
    logic [15:0]              drop_q, drop_d;
    logic                     accept, pop, drop;

    assign accept = sample_valid && !clear;
    assign pop    = rd_en && !clear;
    // While full, a sample only reaches the FIFO if a pop frees a slot the same cycle.
    assign drop   = accept && fifo_full && !pop;

    sample_fifo #(.WIDTH(COUNTER_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (accept),
        .pop   (pop),
        .din   (sample_bitrate),
        .dout  (rd_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset || clear)
            state_q <= NO_DATA;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = accept ? ACTIVE : state_q;
    end

    always_comb begin
        stats_valid = state_q == ACTIVE;
    end

    // The first sample after reset/clear seeds min and max regardless of their zeroed contents.
    always_comb begin
        sum         = acc_q + ACC_W'(sample_bitrate);
        last_d      = accept ? sample_bitrate : last_q;
        min_d       = accept && (state_q == NO_DATA || sample_bitrate < min_q) ? sample_bitrate : min_q;
        max_d       = accept && (state_q == NO_DATA || sample_bitrate > max_q) ? sample_bitrate : max_q;
        avg_valid_d = accept && &cnt_q;
        avg_d       = avg_valid_d ? sum[ACC_W-1:AVG_LOG2] : avg_q;
        acc_d       = accept ? (avg_valid_d ? '0 : sum) : acc_q;
        cnt_d       = accept ? cnt_q + 1'b1 : cnt_q;
        overflow_d  = overflow_q || drop;
        drop_d      = drop && drop_q != 16'hFFFF ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            last_q      <= '0;
            min_q       <= '0;
            max_q       <= '0;
            avg_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            avg_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_q      <= '0;
        end else begin
            last_q      <= last_d;
            min_q       <= min_d;
            max_q       <= max_d;
            avg_q       <= avg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            avg_valid_q <= avg_valid_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
        end
    end

    assign last_bitrate = last_q;
    assign min_bitrate  = min_q;
    assign max_bitrate  = max_q;
    assign avg_bitrate  = avg_q;
    assign avg_valid    = avg_valid_q;
    assign overflow     = overflow_q;
    assign drop_count   = drop_q;
endmodule

// File: tb/tb_bitrate_stats_collector.sv
// tb_bitrate_stats_collector: directed self-checking bench for bitrate_stats_collector.
module tb_bitrate_stats_collector;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [31:0] sample_bitrate = '0;
    logic        clear = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data, last_bitrate, min_bitrate, max_bitrate, avg_bitrate;
    logic        fifo_empty, fifo_full, stats_valid, avg_valid, overflow;
    logic [4:0]  fifo_count;
    logic [15:0] drop_count;
    int          n_checks = 0;
    int          n_fails = 0;

    bitrate_stats_collector dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample_bitrate (sample_bitrate),
        .clear          (clear),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fifo_count     (fifo_count),
        .last_bitrate   (last_bitrate),
        .min_bitrate    (min_bitrate),
        .max_bitrate    (max_bitrate),
        .avg_bitrate    (avg_bitrate),
        .stats_valid    (stats_valid),
        .avg_valid      (avg_valid),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] v);
        sample_valid   = 1'b1;
        sample_bitrate = v;
        tick();
        sample_valid   = 1'b0;
    endtask

    task automatic pop(input logic [31:0] exp, input string tag);
        chk(tag, rd_data, exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        repeat (10) tick();
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_last", last_bitrate, 0);
        chk("rst_min", min_bitrate, 0);
        chk("rst_max", max_bitrate, 0);
        chk("rst_avg", avg_bitrate, 0);
        chk("rst_stats_valid", stats_valid, 0);
        chk("rst_avg_valid", avg_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop", drop_count, 0);
        reset = 1'b0;
        tick();

        // basic stats and FWFT order
        push(100);
        chk("lat_last", last_bitrate, 100);
        chk("lat_stats_valid", stats_valid, 1);
        chk("first_min", min_bitrate, 100);
        chk("first_max", max_bitrate, 100);
        push(300);
        push(200);
        chk("b_min", min_bitrate, 100);
        chk("b_max", max_bitrate, 300);
        chk("b_last", last_bitrate, 200);
        chk("b_count", fifo_count, 3);
        pop(100, "b_pop0");
        pop(300, "b_pop1");
        pop(200, "b_pop2");
        chk("b_empty", fifo_empty, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("empty_pop_count", fifo_count, 0);
        chk("empty_pop_ovf", overflow, 0);
        chk("empty_pop_empty", fifo_empty, 1);

        // averaging
        do_clear();
        for (int i = 0; i < 7; i++) push(51200);
        chk("avg_not_yet", avg_valid, 0);
        push(51200);
        chk("avg_pulse", avg_valid, 1);
        chk("avg_val", avg_bitrate, 51200);
        tick();
        chk("avg_pulse_end", avg_valid, 0);
        chk("avg_hold", avg_bitrate, 51200);
        for (int i = 1; i <= 7; i++) push(i);
        chk("avg2_not_yet", avg_valid, 0);
        push(8);
        chk("avg2_pulse", avg_valid, 1);
        chk("avg2_val", avg_bitrate, 4);
        chk("avg2_min", min_bitrate, 1);
        chk("avg2_max", max_bitrate, 51200);
        chk("avg2_full", fifo_full, 1);

        // overflow
        do_clear();
        for (int i = 1; i <= 17; i++) push(i);
        chk("ovf_full", fifo_full, 1);
        chk("ovf_count", fifo_count, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", drop_count, 1);
        chk("ovf_last", last_bitrate, 17);
        chk("ovf_max", max_bitrate, 17);
        push(18);
        chk("ovf_drop2", drop_count, 2);
        for (int i = 1; i <= 16; i++) pop(i, "ovf_pop");
        chk("ovf_empty", fifo_empty, 1);
        chk("ovf_sticky", overflow, 1);

        // push+pop while full, push+pop while empty
        do_clear();
        for (int i = 1; i <= 16; i++) push(i);
        chk("pp_full", fifo_full, 1);
        rd_en = 1'b1;
        push(99);
        rd_en = 1'b0;
        chk("pp_count", fifo_count, 16);
        chk("pp_drop", drop_count, 0);
        chk("pp_ovf", overflow, 0);
        for (int i = 2; i <= 16; i++) pop(i, "pp_pop");
        pop(99, "pp_last_out");
        chk("pp_empty", fifo_empty, 1);
        rd_en = 1'b1;
        push(77);
        rd_en = 1'b0;
        chk("pe_count", fifo_count, 1);
        chk("pe_rd_data", rd_data, 77);

        // clear beats a simultaneous sample
        do_clear();
        for (int i = 1; i <= 5; i++) push(i * 10);
        clear = 1'b1;
        rd_en = 1'b1;
        push(999);
        clear = 1'b0;
        rd_en = 1'b0;
        chk("clr_last", last_bitrate, 0);
        chk("clr_min", min_bitrate, 0);
        chk("clr_max", max_bitrate, 0);
        chk("clr_avg", avg_bitrate, 0);
        chk("clr_empty", fifo_empty, 1);
        chk("clr_count", fifo_count, 0);
        chk("clr_stats_valid", stats_valid, 0);
        tick();
        chk("clr_not_stored", fifo_empty, 1);

        // reset mid-window discards partial average
        push(5);
        push(6);
        push(7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_empty", fifo_empty, 1);
        for (int i = 0; i < 5; i++) push(80);
        chk("mr_no_stale", avg_valid, 0);
        push(80);
        push(80);
        push(160);
        chk("mr_pulse", avg_valid, 1);
        chk("mr_avg", avg_bitrate, 90);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
